// File: rtl/demux_l1_pkg.sv
// Shared definitions for the layer-1 mux/demux pair: lane widths, slot encoding
// and the zero-if-invalid mask helper.
package demux_l1_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 8;

    typedef enum logic {
        SLOT0 = 1'b0,
        SLOT1 = 1'b1
    } slot_t;

    // 1 keeps the captured byte, 0 forces it to zero
    function automatic logic keep_data(input logic valid, input logic zero_invalid);
        return valid | ~zero_invalid;
    endfunction

endpackage

// File: rtl/lane_deser_1to2.sv
// Splits one time-multiplexed byte lane into its two channels, using the
// phase supplied by the top so both lanes stay frame-aligned.
module lane_deser_1to2
    import demux_l1_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter bit          ZERO_INVALID = 1'b1
) (
    input  logic              clk_2f,
    input  logic              reset_L,
    input  slot_t             phase,
    input  logic [DATA_W-1:0] lane_data,
    input  logic              lane_valid,
    output logic [DATA_W-1:0] data_a,
    output logic              valid_a,
    output logic [DATA_W-1:0] data_b,
    output logic              valid_b,
    output logic              any_valid_c
);

    logic [DATA_W-1:0] hold_data;
    logic              hold_valid;

    // Valid state of the frame being completed on this edge
    assign any_valid_c = hold_valid | lane_valid;

    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            data_a     <= '0;
            valid_a    <= 1'b0;
            data_b     <= '0;
            valid_b    <= 1'b0;
        end else if (phase == SLOT0) begin
            hold_data  <= lane_data;
            hold_valid <= lane_valid;
        end else begin
            data_a  <= hold_data & {DATA_W{keep_data(hold_valid, ZERO_INVALID)}};
            valid_a <= hold_valid;
            data_b  <= lane_data & {DATA_W{keep_data(lane_valid, ZERO_INVALID)}};
            valid_b <= lane_valid;
        end
    end

endmodule

// File: rtl/demux_l1.sv
// Layer-1 demultiplexer: rebuilds four byte channels from two 2-slot lanes,
// with a frame strobe and a count of frames carrying any valid channel.
module demux_l1
    import demux_l1_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter bit          ZERO_INVALID = 1'b1,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic              clk_2f,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_00,
    input  logic              valid_00,
    input  logic [DATA_W-1:0] data_11,
    input  logic              valid_11,
    output logic [DATA_W-1:0] data_0,
    output logic [DATA_W-1:0] data_1,
    output logic [DATA_W-1:0] data_2,
    output logic [DATA_W-1:0] data_3,
    output logic              valid_0,
    output logic              valid_1,
    output logic              valid_2,
    output logic              valid_3,
    output logic              frame_stb,
    output logic [CNT_W-1:0]  frame_cnt
);

    slot_t phase;
    logic  any_00_c;
    logic  any_11_c;

    lane_deser_1to2 #(
        .DATA_W       (DATA_W),
        .ZERO_INVALID (ZERO_INVALID)
    ) u_lane_00 (
        .clk_2f      (clk_2f),
        .reset_L     (reset_L),
        .phase       (phase),
        .lane_data   (data_00),
        .lane_valid  (valid_00),
        .data_a      (data_0),
        .valid_a     (valid_0),
        .data_b      (data_1),
        .valid_b     (valid_1),
        .any_valid_c (any_00_c)
    );

    lane_deser_1to2 #(
        .DATA_W       (DATA_W),
        .ZERO_INVALID (ZERO_INVALID)
    ) u_lane_11 (
        .clk_2f      (clk_2f),
        .reset_L     (reset_L),
        .phase       (phase),
        .lane_data   (data_11),
        .lane_valid  (valid_11),
        .data_a      (data_2),
        .valid_a     (valid_2),
        .data_b      (data_3),
        .valid_b     (valid_3),
        .any_valid_c (any_11_c)
    );

    // Slot phase, frame strobe and frame counter; alignment comes from reset only
    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            phase     <= SLOT0;
            frame_stb <= 1'b0;
            frame_cnt <= '0;
        end else if (phase == SLOT0) begin
            phase     <= SLOT1;
            frame_stb <= 1'b0;
        end else begin
            phase     <= SLOT0;
            frame_stb <= 1'b1;
            if (any_00_c | any_11_c) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux_l1.sv
// Scoreboard bench for demux_l1: frames go in as four-channel records, the
// expected output of each frame is queued and checked when frame_stb fires.
module tb_demux_l1;

    typedef struct packed {
        logic [3:0][7:0] d;
        logic [3:0]      v;
        logic [7:0]      cnt;
    } exp_t;

    logic       clk_2f;
    logic       reset_L;
    logic [7:0] data_00, data_11;
    logic       valid_00, valid_11;
    logic [7:0] data_0, data_1, data_2, data_3;
    logic       valid_0, valid_1, valid_2, valid_3;
    logic       frame_stb;
    logic [7:0] frame_cnt;

    demux_l1 #(.DATA_W(8), .ZERO_INVALID(1'b1), .CNT_W(8)) dut (
        .clk_2f    (clk_2f),
        .reset_L   (reset_L),
        .data_00   (data_00),
        .valid_00  (valid_00),
        .data_11   (data_11),
        .valid_11  (valid_11),
        .data_0    (data_0),
        .data_1    (data_1),
        .data_2    (data_2),
        .data_3    (data_3),
        .valid_0   (valid_0),
        .valid_1   (valid_1),
        .valid_2   (valid_2),
        .valid_3   (valid_3),
        .frame_stb (frame_stb),
        .frame_cnt (frame_cnt)
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    logic [7:0] model_cnt = 8'd0;
    logic rst_q = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a frame is four channels; invalid channels read back as zero
    function automatic exp_t model_frame(input logic [3:0][7:0] d, input logic [3:0] v);
        exp_t e;
        for (int i = 0; i < 4; i++) e.d[i] = v[i] ? d[i] : 8'h00;
        e.v = v;
        if (v != 4'b0000) model_cnt = model_cnt + 8'd1;
        e.cnt = model_cnt;
        return e;
    endfunction

    // Called at a negedge where slot 0 is due; returns at the negedge after slot 1
    task automatic send_frame(input logic [3:0][7:0] d, input logic [3:0] v, input bit rst_mid);
        data_00 = d[0]; valid_00 = v[0];
        data_11 = d[2]; valid_11 = v[2];
        @(negedge clk_2f);
        data_00 = d[1]; valid_00 = v[1];
        data_11 = d[3]; valid_11 = v[3];
        if (rst_mid) begin
            reset_L   = 1'b0;
            model_cnt = 8'd0;
        end else begin
            exp_q.push_back(model_frame(d, v));
        end
        @(negedge clk_2f);
    endtask

    task automatic rand_frame();
        logic [3:0][7:0] d;
        logic [3:0]      v;
        d = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        v = 4'($urandom);
        send_frame(d, v, 1'b0);
    endtask

    always @(posedge clk_2f) rst_q <= reset_L;

    // Monitor: reset clears, strobe pops a frame, outputs otherwise hold
    initial begin
        exp_t cur;
        cur = '0;
        @(posedge clk_2f);
        forever begin
            @(negedge clk_2f);
            if (!rst_q) begin
                cur = '0;
                chk("reset_data", 64'({data_3, data_2, data_1, data_0}), 64'(0));
                chk("reset_valid", 64'({valid_3, valid_2, valid_1, valid_0}), 64'(0));
                chk("reset_stb", 64'(frame_stb), 64'(0));
                chk("reset_cnt", 64'(frame_cnt), 64'(0));
            end else begin
                if (frame_stb === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_strobe: got frame_stb=1 expected no frame pending at %0t", $time);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                chk("data", 64'({data_3, data_2, data_1, data_0}), 64'(cur.d));
                chk("valid", 64'({valid_3, valid_2, valid_1, valid_0}), 64'(cur.v));
                chk("frame_cnt", 64'(frame_cnt), 64'(cur.cnt));
            end
        end
    end

    initial begin
        reset_L = 1'b0;
        data_00 = '0; data_11 = '0; valid_00 = 1'b0; valid_11 = 1'b0;
        // Reset hold with random lane traffic
        repeat (4) begin
            @(negedge clk_2f);
            data_00 = 8'($urandom); data_11 = 8'($urandom);
            valid_00 = 1'($urandom); valid_11 = 1'($urandom);
        end
        @(negedge clk_2f);
        reset_L = 1'b1;
        // Directed frames: full, back-to-back, partial, all invalid
        send_frame({8'hCC, 8'hDD, 8'hEE, 8'hFF}, 4'b1111, 1'b0);
        send_frame({8'h88, 8'h99, 8'hAA, 8'hBB}, 4'b1111, 1'b0);
        send_frame({8'h77, 8'($urandom), 8'($urandom), 8'($urandom)}, 4'b1000, 1'b0);
        send_frame({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 4'b0000, 1'b0);
        send_frame({8'h00, 8'h00, 8'h5A, 8'h00}, 4'b0010, 1'b0);
        repeat (20) rand_frame();
        // Reset on a slot-1 edge drops the partial frame
        send_frame({8'h11, 8'h22, 8'h33, 8'h44}, 4'b1111, 1'b1);
        repeat (2) @(negedge clk_2f);
        reset_L = 1'b1;
        // 256 frames with at least one valid channel: counter wraps to zero
        send_frame({8'h12, 8'h34, 8'h56, 8'h78}, 4'b1111, 1'b0);
        for (int i = 1; i < 256; i++) begin
            logic [3:0][7:0] d;
            d = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            send_frame(d, 4'($urandom_range(1, 15)), 1'b0);
        end
        send_frame({8'h01, 8'h02, 8'h03, 8'h04}, 4'b0000, 1'b0);
        repeat (6) rand_frame();
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
